// File: rtl/team_05_wb_pkg.sv
// -----------------------------------------------------------------------------
// team_05_wb_pkg
// Shared definitions for the Wishbone classic responder:
//   - wb_state_e     : responder FSM states (IDLE, WAIT, ACK)
//   - WORDS / IDX_W  : backing store geometry (64 words, 6-bit word index)
//   - READ_MISS_DATA : value returned for reads outside the window
//   - lane_mask()    : expands a 4-bit byte select into a 32-bit bit mask
//   - merge_lanes()  : replaces only the selected byte lanes of a word
// -----------------------------------------------------------------------------
package team_05_wb_pkg;

  localparam int          WORDS          = 64;
  localparam int          IDX_W          = 6;
  localparam logic [31:0] READ_MISS_DATA = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } wb_state_e;

  // Byte select bit n enables data bits [8n+7:8n].
  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    logic [31:0] m;
    m = 32'h0000_0000;
    for (int n = 0; n < 4; n++) begin
      m[8*n +: 8] = {8{sel[n]}};
    end
    return m;
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  sel);
    logic [31:0] m;
    m = lane_mask(sel);
    return (old_word & ~m) | (new_word & m);
  endfunction

endpackage

// File: rtl/team_05_wb_mem.sv
// -----------------------------------------------------------------------------
// team_05_wb_mem
// 64 x 32-bit storage for the responder window. All words clear on reset.
// Ports:
//   clk_i    : clock, write on rising edge
//   rst_i    : asynchronous active-high reset, clears every word
//   we_i     : write enable for this cycle
//   widx_i   : word index written
//   sel_i    : byte-lane enables for the write
//   wdata_i  : write data
//   ridx_i   : word index read
//   rdata_o  : combinational read data
// -----------------------------------------------------------------------------
module team_05_wb_mem
  import team_05_wb_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] widx_i,
  input  logic [3:0]       sel_i,
  input  logic [31:0]      wdata_i,
  input  logic [IDX_W-1:0] ridx_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [WORDS];

  // Storage array: cleared on reset, byte-masked update on write.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < WORDS; i++) begin
        mem_q[i] <= 32'h0000_0000;
      end
    end else if (we_i) begin
      mem_q[widx_i] <= merge_lanes(mem_q[widx_i], wdata_i, sel_i);
    end
  end

  assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/team_05_wb_responder.sv
// -----------------------------------------------------------------------------
// team_05_wb_responder
// Wishbone classic (non-pipelined) responder with a 256-byte window backed
// by 64 x 32-bit words. Each transfer is acknowledged 1 + WAIT_STATES cycles
// after it is first sampled; misses are acknowledged too (reads return 0,
// writes are dropped). Dropping CYC_I/STB_I during the wait aborts it.
// Parameters:
//   BASE_ADDR   : byte base of the window, bits [7:0] ignored
//   WAIT_STATES : extra cycles before ACK_O (0..15)
// Ports:
//   wb_clk_i  : clock            wb_rst_i : async active-high reset
//   ADR_I     : byte address     DAT_I    : write data
//   SEL_I     : byte lanes       WE_I     : 1 = write
//   STB_I     : strobe           CYC_I    : cycle valid
//   DAT_O     : read data (non-zero only in the ACK cycle of a hit read)
//   ACK_O     : one-cycle acknowledge
//   busy_o    : FSM not in IDLE
// -----------------------------------------------------------------------------
module team_05_wb_responder
  import team_05_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] ADR_I,
  input  logic [31:0] DAT_I,
  input  logic [3:0]  SEL_I,
  input  logic        WE_I,
  input  logic        STB_I,
  input  logic        CYC_I,
  output logic [31:0] DAT_O,
  output logic        ACK_O,
  output logic        busy_o
);

  localparam bit         HAS_WAIT  = (WAIT_STATES != 0);
  // Counter value in the final wait cycle; unused when HAS_WAIT is 0.
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES - 1);

  wb_state_e        state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;

  // Latched request fields
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      wdat_q;
  logic [3:0]       sel_q;
  logic             we_q;
  logic             hit_q;

  // Registered outputs
  logic             ack_q;
  logic [31:0]      rdat_q, rdat_d;
  logic             busy_q;

  logic             req_s;
  logic             hit_s;
  logic             lat_en_s;
  logic [IDX_W-1:0] rd_idx_s;
  logic             rd_hit_s;
  logic             rd_we_s;
  logic [31:0]      mem_rdata_s;
  logic             mem_we_s;
  logic             unused_s;

  assign req_s    = CYC_I & STB_I;
  assign hit_s    = (ADR_I[31:8] == BASE_ADDR[31:8]);
  assign unused_s = ^ADR_I[1:0];

  // Next-state logic: IDLE accepts, WAIT counts or aborts, ACK returns to IDLE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lat_en_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_s) begin
          lat_en_s = 1'b1;
          cnt_d    = 4'd0;
          state_d  = HAS_WAIT ? WAIT : ACK;
        end else begin
          state_d  = IDLE;
        end
      end
      WAIT: begin
        if (!req_s) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == WAIT_LAST) begin
          state_d = ACK;
          cnt_d   = 4'd0;
        end else begin
          cnt_d   = cnt_q + 4'd1;
        end
      end
      ACK: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // With zero wait states ACK follows IDLE directly, so the read index must
  // come from the live bus rather than the not-yet-latched fields.
  always_comb begin
    if (lat_en_s) begin
      rd_idx_s = ADR_I[7:2];
      rd_hit_s = hit_s;
      rd_we_s  = WE_I;
    end else begin
      rd_idx_s = idx_q;
      rd_hit_s = hit_q;
      rd_we_s  = we_q;
    end
    if (state_d == ACK) begin
      rdat_d = (rd_hit_s && !rd_we_s) ? mem_rdata_s : READ_MISS_DATA;
    end else begin
      rdat_d = 32'h0000_0000;
    end
  end

  // FSM state and wait counter.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request capture on acceptance in IDLE; held for the rest of the transfer.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      idx_q  <= '0;
      wdat_q <= 32'h0000_0000;
      sel_q  <= 4'h0;
      we_q   <= 1'b0;
      hit_q  <= 1'b0;
    end else if (lat_en_s) begin
      idx_q  <= ADR_I[7:2];
      wdat_q <= DAT_I;
      sel_q  <= SEL_I;
      we_q   <= WE_I;
      hit_q  <= hit_s;
    end
  end

  // Output registers, loaded from the next state so they line up with it.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q  <= 1'b0;
      rdat_q <= 32'h0000_0000;
      busy_q <= 1'b0;
    end else begin
      ack_q  <= (state_d == ACK);
      rdat_q <= rdat_d;
      busy_q <= (state_d != IDLE);
    end
  end

  // Write commits on the clock edge that ends the ACK cycle.
  assign mem_we_s = (state_q == ACK) && we_q && hit_q;

  team_05_wb_mem u_mem (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .we_i    (mem_we_s),
    .widx_i  (idx_q),
    .sel_i   (sel_q),
    .wdata_i (wdat_q),
    .ridx_i  (rd_idx_s),
    .rdata_o (mem_rdata_s)
  );

  assign ACK_O  = ack_q;
  assign DAT_O  = rdat_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_team_05_wb_responder.sv
// -----------------------------------------------------------------------------
// tb_team_05_wb_responder
// Directed bench with three responders (WAIT_STATES = 1, 3, 0) on a shared
// clock and reset, each with its own bus inputs.
// -----------------------------------------------------------------------------
module tb_team_05_wb_responder;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] adr [3];
  logic [31:0] dat [3];
  logic [3:0]  sel [3];
  logic        we  [3];
  logic        stb [3];
  logic        cyc [3];

  logic [31:0] dout0, dout1, dout2;
  logic        ack0, ack1, ack2;
  logic        busy0, busy1, busy2;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] model [64];

  team_05_wb_responder #(.BASE_ADDR(BASE), .WAIT_STATES(1)) u_w1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .ADR_I(adr[0]), .DAT_I(dat[0]),
    .SEL_I(sel[0]), .WE_I(we[0]), .STB_I(stb[0]), .CYC_I(cyc[0]),
    .DAT_O(dout0), .ACK_O(ack0), .busy_o(busy0));

  team_05_wb_responder #(.BASE_ADDR(BASE), .WAIT_STATES(3)) u_w3 (
    .wb_clk_i(clk), .wb_rst_i(rst), .ADR_I(adr[1]), .DAT_I(dat[1]),
    .SEL_I(sel[1]), .WE_I(we[1]), .STB_I(stb[1]), .CYC_I(cyc[1]),
    .DAT_O(dout1), .ACK_O(ack1), .busy_o(busy1));

  team_05_wb_responder #(.BASE_ADDR(BASE), .WAIT_STATES(0)) u_w0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .ADR_I(adr[2]), .DAT_I(dat[2]),
    .SEL_I(sel[2]), .WE_I(we[2]), .STB_I(stb[2]), .CYC_I(cyc[2]),
    .DAT_O(dout2), .ACK_O(ack2), .busy_o(busy2));

  function automatic logic get_ack(input int k);
    case (k)
      0:       return ack0;
      1:       return ack1;
      default: return ack2;
    endcase
  endfunction

  function automatic logic [31:0] get_dat(input int k);
    case (k)
      0:       return dout0;
      1:       return dout1;
      default: return dout2;
    endcase
  endfunction

  function automatic logic get_busy(input int k);
    case (k)
      0:       return busy0;
      1:       return busy1;
      default: return busy2;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Runs one transfer starting just after a rising edge. ncyc is the cycle
  // (request cycle = 0) in which ACK_O was seen, or -1 on timeout.
  task automatic xfer(input int k, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s, input string tag,
                      output logic [31:0] rd, output int ncyc);
    cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; dat[k] = d; sel[k] = s;
    ncyc = -1;
    rd   = 32'h0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (get_ack(k)) begin
        ncyc = n;
        rd   = get_dat(k);
        break;
      end
    end
    cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
    if (ncyc < 0) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      @(posedge clk); #1;
      chk({tag, "_ack_drop"}, {31'd0, get_ack(k)}, 32'd0);
      chk({tag, "_dat_idle"}, get_dat(k), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] rd;
    int          nc;
    int          acks;

    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      adr[k] = 32'h0; dat[k] = 32'h0; sel[k] = 4'h0;
      we[k] = 1'b0; stb[k] = 1'b0; cyc[k] = 1'b0;
    end
    for (int i = 0; i < 64; i++) model[i] = 32'h0;

    #2;
    chk("rst_ack",  {31'd0, ack0},  32'd0);
    chk("rst_dat",  dout0,          32'd0);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // ---------------- WAIT_STATES = 1 ----------------
    xfer(0, 1'b1, BASE + 32'h0C, 32'hA5A5_1234, 4'hF, "w0c", rd, nc);
    chk("w0c_lat", 32'(nc), 32'd2);
    model[3] = 32'hA5A5_1234;
    xfer(0, 1'b0, BASE + 32'h0C, 32'h0, 4'hF, "r0c", rd, nc);
    chk("r0c_lat", 32'(nc), 32'd2);
    chk("r0c_dat", rd, 32'hA5A5_1234);

    xfer(0, 1'b1, BASE + 32'h10, 32'h1122_3344, 4'hF, "w10", rd, nc);
    xfer(0, 1'b1, BASE + 32'h10, 32'h0000_FF00, 4'b0010, "w10_lane", rd, nc);
    model[4] = 32'h1122_FF44;
    xfer(0, 1'b0, BASE + 32'h10, 32'h0, 4'hF, "r10", rd, nc);
    chk("r10_dat", rd, 32'h1122_FF44);

    xfer(0, 1'b1, BASE + 32'h0C, 32'h0000_0000, 4'h0, "w0c_sel0", rd, nc);
    chk("w0c_sel0_lat", 32'(nc), 32'd2);
    xfer(0, 1'b0, BASE + 32'h0C, 32'h0, 4'hF, "r0c_sel0", rd, nc);
    chk("r0c_sel0_dat", rd, 32'hA5A5_1234);

    xfer(0, 1'b0, BASE + 32'h100, 32'h0, 4'hF, "rmiss", rd, nc);
    chk("rmiss_lat", 32'(nc), 32'd2);
    chk("rmiss_dat", rd, 32'h0);
    xfer(0, 1'b1, BASE + 32'h100, 32'hFFFF_FFFF, 4'hF, "wmiss", rd, nc);
    chk("wmiss_lat", 32'(nc), 32'd2);
    for (int i = 0; i < 64; i++) begin
      xfer(0, 1'b0, BASE + 32'(i * 4), 32'h0, 4'hF, "scan", rd, nc);
      chk($sformatf("scan_%0d", i), rd, model[i]);
    end

    // ---------------- WAIT_STATES = 3 ----------------
    xfer(1, 1'b1, BASE + 32'h08, 32'hDEAD_BEEF, 4'hF, "w3_w08", rd, nc);
    chk("w3_w08_lat", 32'(nc), 32'd4);
    xfer(1, 1'b0, BASE + 32'h08, 32'h0, 4'hF, "w3_r08", rd, nc);
    chk("w3_r08_dat", rd, 32'hDEAD_BEEF);

    // Abort in WAIT
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1;
    adr[1] = BASE + 32'h20; dat[1] = 32'h1234_5678; sel[1] = 4'hF;
    @(posedge clk); #1;
    chk("abort_busy_wait", {31'd0, get_busy(1)}, 32'd1);
    @(posedge clk); #1;
    chk("abort_ack_wait", {31'd0, get_ack(1)}, 32'd0);
    cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy_low", {31'd0, get_busy(1)}, 32'd0);
    acks = 0;
    for (int n = 0; n < 5; n++) begin
      if (get_ack(1)) acks++;
      @(posedge clk); #1;
    end
    chk("abort_no_ack", 32'(acks), 32'd0);
    xfer(1, 1'b0, BASE + 32'h20, 32'h0, 4'hF, "abort_r20", rd, nc);
    chk("abort_r20_dat", rd, 32'h0);
    chk("abort_r20_lat", 32'(nc), 32'd4);

    // Reset in WAIT
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1;
    adr[1] = BASE + 32'h04; dat[1] = 32'hCAFE_F00D; sel[1] = 4'hF;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rstw_ack",  {31'd0, get_ack(1)},  32'd0);
    chk("rstw_busy", {31'd0, get_busy(1)}, 32'd0);
    cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
    #2;
    rst = 1'b0;
    acks = 0;
    for (int n = 0; n < 5; n++) begin
      @(posedge clk); #1;
      if (get_ack(1)) acks++;
    end
    chk("rstw_no_ack", 32'(acks), 32'd0);
    xfer(1, 1'b0, BASE + 32'h04, 32'h0, 4'hF, "rstw_r04", rd, nc);
    chk("rstw_r04_dat", rd, 32'h0);
    xfer(1, 1'b0, BASE + 32'h08, 32'h0, 4'hF, "rstw_r08", rd, nc);
    chk("rstw_r08_dat", rd, 32'h0);
    xfer(1, 1'b1, BASE + 32'h04, 32'h7777_0001, 4'hF, "rstw_w04", rd, nc);
    chk("rstw_w04_lat", 32'(nc), 32'd4);
    xfer(1, 1'b0, BASE + 32'h04, 32'h0, 4'hF, "rstw_rb04", rd, nc);
    chk("rstw_rb04_dat", rd, 32'h7777_0001);

    // ---------------- WAIT_STATES = 0 ----------------
    xfer(2, 1'b1, BASE + 32'h00, 32'h0101_0101, 4'hF, "w0_w00", rd, nc);
    chk("w0_w00_lat", 32'(nc), 32'd1);
    xfer(2, 1'b1, BASE + 32'h04, 32'h0202_0202, 4'hF, "w0_w04", rd, nc);
    chk("w0_w04_lat", 32'(nc), 32'd1);

    // Back-to-back reads with STB_I held high
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b0; sel[2] = 4'hF;
    adr[2] = BASE + 32'h00;
    @(posedge clk); #1;
    chk("b2b_ack_c1", {31'd0, get_ack(2)}, 32'd1);
    chk("b2b_dat_c1", get_dat(2), 32'h0101_0101);
    adr[2] = BASE + 32'h04;
    @(posedge clk); #1;
    chk("b2b_ack_c2", {31'd0, get_ack(2)}, 32'd0);
    chk("b2b_dat_c2", get_dat(2), 32'h0);
    @(posedge clk); #1;
    chk("b2b_ack_c3", {31'd0, get_ack(2)}, 32'd1);
    chk("b2b_dat_c3", get_dat(2), 32'h0202_0202);
    cyc[2] = 1'b0; stb[2] = 1'b0;
    @(posedge clk); #1;
    chk("b2b_ack_c4", {31'd0, get_ack(2)}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/team_05_wb_responder.md
TEAM_05_WB_RESPONDER -- requirements
Module: team_05_wb_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, byte base address of the responder window (bits [7:0] ignored).
REQ-002 SHALL have parameter WAIT_STATES, default 1, range 0..15: extra cycles inserted before ACK_O.
REQ-003 SHALL have port wb_clk_i  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port wb_rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port ADR_I  input  32  byte address from interconnect.
REQ-006 SHALL have port DAT_I  input  32  write data.
REQ-007 SHALL have port SEL_I  input  4  byte-lane enables, bit n = DAT_I[8n+7:8n].
REQ-008 SHALL have port WE_I  input  1  1 = write, 0 = read.
REQ-009 SHALL have port STB_I  input  1  strobe.
REQ-010 SHALL have port CYC_I  input  1  bus cycle valid.
REQ-011 SHALL have port DAT_O  output  32  read data.
REQ-012 SHALL have port ACK_O  output  1  single-cycle transfer acknowledge.
REQ-013 SHALL have port busy_o  output  1  high whenever FSM is not IDLE.

Function
REQ-014 SHALL implement Wishbone classic (non-pipelined) responder backed by 64 x 32-bit words (256-byte window).
REQ-015 SHALL decode hit = (ADR_I[31:8] == BASE_ADDR[31:8]); word index = ADR_I[7:2]; ADR_I[1:0] ignored.
REQ-016 SHALL use FSM states IDLE, WAIT, ACK.
REQ-017 IDLE: on CYC_I & STB_I, SHALL latch ADR_I, DAT_I, SEL_I, WE_I, hit; go to WAIT if WAIT_STATES>0, else ACK.
REQ-018 WAIT: SHALL count WAIT_STATES cycles with a 4-bit counter, then go to ACK.
REQ-019 ACK: ACK_O SHALL be high exactly one cycle; next state IDLE unconditionally.
REQ-020 Latency: request first sampled in cycle 0 SHALL produce ACK_O in cycle 1+WAIT_STATES.
REQ-021 Write with hit SHALL update only lanes with latched SEL set, on the ACK-cycle clock edge; SEL=0000 SHALL ack with no change.
REQ-022 Read with hit SHALL drive DAT_O = stored word during the ACK cycle; DAT_O SHALL be 32'h0 in all other cycles.
REQ-023 Miss (hit=0) SHALL still be acknowledged with same latency; reads return 32'h0, writes are discarded.
REQ-024 CYC_I or STB_I low while in WAIT SHALL abort: return to IDLE next cycle, no ACK_O, no memory write.
REQ-025 Back-to-back: STB_I still high in the cycle after ACK (FSM in IDLE) SHALL start a new transaction; minimum spacing between ACKs is 2+WAIT_STATES cycles.
REQ-026 Request inputs SHALL be ignored outside IDLE except CYC_I/STB_I abort check.

Reset
REQ-027 wb_rst_i high SHALL immediately force state IDLE, wait counter 0, ACK_O=0, DAT_O=0, busy_o=0, all latched request fields 0.
REQ-028 All 64 memory words SHALL reset to 32'h0.
REQ-029 Reset mid-transaction SHALL drop it: no ACK_O, no write, including reset asserted during ACK cycle.

Structure
REQ-030 Package team_05_wb_pkg SHALL hold state enum (IDLE, WAIT, ACK), WORDS=64, IDX_W=6, READ_MISS_DATA=32'h0.
REQ-031 SHALL contain one sub-module team_05_wb_mem: 64x32 array, async reset, byte-masked write port, combinational read port.
REQ-032 FSM, decode, and output registers SHALL live in team_05_wb_responder.

Verification
REQ-033 W=1: write 32'hA5A5_1234 to BASE+0x0C, SEL=1111 -> ACK_O in cycle 2 only; subsequent read of BASE+0x0C returns 32'hA5A5_1234 in its ACK cycle.
REQ-034 Word at BASE+0x10 = 32'h1122_3344; write DAT_I=32'h0000_FF00, SEL=0010 -> read back 32'h1122_FF44.
REQ-035 Read BASE+0x100 and write 32'hFFFF_FFFF to BASE+0x100 -> both ACK at normal latency, read DAT_O=0, all 64 words unchanged.
REQ-036 W=3: write started, STB_I/CYC_I dropped in WAIT -> no ACK_O, busy_o low next cycle, target word unchanged.
REQ-037 wb_rst_i pulsed during WAIT of write to BASE+0x04 -> ACK_O stays 0, word reads 0 after reset, next transaction completes normally.
REQ-038 W=0, STB_I held high for two reads to BASE+0x00 and BASE+0x04 -> ACK_O in cycles 1 and 3, correct data each.
